// File: rtl/gpu_bus_pkg.sv
// Shared constants, control-word layout and state encoding for the GPU frame uploader.
package gpu_bus_pkg;

  localparam int unsigned BUS_W   = 64;
  localparam int unsigned INDEX_W = 11;
  localparam int unsigned POLL_W  = 24;
  localparam int unsigned COLOR_W = 12;

  localparam logic [7:0]         GPU_ADDRESS           = 8'b00000010;
  localparam logic [INDEX_W-1:0] GPU_CONTROL_ADDRESS   = 11'd0;
  localparam logic [INDEX_W-1:0] GPU_CHARS_ADDRESS_MIN = 11'd4;
  localparam logic [INDEX_W-1:0] CHAR_COUNT            = 11'd1200;
  localparam logic [POLL_W-1:0]  POLL_LIMIT            = 24'd2000000;

  // Control word layout (written by the uploader)
  localparam int unsigned CTRL_COPY_BIT  = 0;
  localparam int unsigned CTRL_BLANK_BIT = 1;
  localparam int unsigned CTRL_MODE_BIT  = 2;
  localparam int unsigned CTRL_COLOR_LSB = 3;
  localparam int unsigned CTRL_COLOR_MSB = 14;

  // Status bits read back from the same word; the GPU clears them when served
  localparam int unsigned STAT_COPY_PENDING  = 0;
  localparam int unsigned STAT_BLANK_PENDING = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_POLL  = 3'd1,
    ST_SRC_READ  = 3'd2,
    ST_GPU_WRITE = 3'd3,
    ST_KICK      = 3'd4,
    ST_POST_POLL = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  function automatic logic [BUS_W-1:0] gpu_word_addr(input logic [7:0] dev,
                                                     input logic [INDEX_W-1:0] off);
    return {dev, 45'b0, off};
  endfunction

  function automatic logic [BUS_W-1:0] ctrl_kick_word(input logic [COLOR_W-1:0] color,
                                                      input logic mode);
    logic [BUS_W-1:0] w;
    w = '0;
    w[CTRL_COPY_BIT]                   = 1'b1;
    w[CTRL_MODE_BIT]                   = mode;
    w[CTRL_COLOR_MSB:CTRL_COLOR_LSB]   = color;
    return w;
  endfunction

endpackage

// File: rtl/gpu_frame_uploader.sv
// Bus-initiator that copies a 1200-word character frame from main memory into the
// GPU framebuffer, kicks the copy-request bit and polls until the GPU acknowledges.
module gpu_frame_uploader
  import gpu_bus_pkg::*;
#(
  parameter logic [7:0]         GPUAddress              = GPU_ADDRESS,
  parameter logic [INDEX_W-1:0] GPUControlAddress       = GPU_CONTROL_ADDRESS,
  parameter logic [INDEX_W-1:0] GPUCharactersAddressMin = GPU_CHARS_ADDRESS_MIN,
  parameter logic [INDEX_W-1:0] CharCount               = CHAR_COUNT,
  parameter logic [POLL_W-1:0]  PollLimit               = POLL_LIMIT
) (
  input  logic               procClock,
  input  logic               reset,
  input  logic               start,
  input  logic [BUS_W-1:0]   srcBase,
  input  logic               displayMode,
  input  logic [COLOR_W-1:0] displayColor,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [BUS_W-1:0]   address,
  inout  wire  [BUS_W-1:0]   data,
  output logic               read,
  output logic               write
);

  state_t               r_state, w_next;
  logic [BUS_W-1:0]     r_base, w_base;
  logic                 r_mode, w_mode;
  logic [COLOR_W-1:0]   r_color, w_color;
  logic [INDEX_W-1:0]   r_index, w_index;
  logic [POLL_W-1:0]    r_poll, w_poll;
  logic [BUS_W-1:0]     r_hold, w_hold;
  logic                 r_error, w_error;
  logic [BUS_W-1:0]     r_addr, w_addr;
  logic [BUS_W-1:0]     r_wdata, w_wdata;
  logic                 r_read, w_read;
  logic                 r_write, w_write;
  logic                 r_busy, r_done;
  logic [BUS_W-1:0]     w_ctrl_addr;

  assign w_ctrl_addr = gpu_word_addr(GPUAddress, GPUControlAddress);

  always_ff @(posedge procClock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Poll states decide on the live bus word; everything else is sequenced by state alone
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_PRE_POLL;
      ST_PRE_POLL:  if (!data[STAT_COPY_PENDING] && !data[STAT_BLANK_PENDING])
                      w_next = ST_SRC_READ;
      ST_SRC_READ:  w_next = ST_GPU_WRITE;
      ST_GPU_WRITE: w_next = (r_index == CharCount - 11'd1) ? ST_KICK : ST_SRC_READ;
      ST_KICK:      w_next = ST_POST_POLL;
      ST_POST_POLL: if (!data[STAT_COPY_PENDING] || (r_poll == PollLimit - 24'd1))
                      w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Next datapath values, and bus outputs derived from the state being entered
  always_comb begin
    w_base  = r_base;
    w_mode  = r_mode;
    w_color = r_color;
    w_index = r_index;
    w_poll  = r_poll;
    w_hold  = r_hold;
    w_error = r_error;
    w_addr  = '0;
    w_wdata = '0;
    w_read  = 1'b0;
    w_write = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_base  = srcBase;
        w_mode  = displayMode;
        w_color = displayColor;
        w_index = '0;
        w_error = 1'b0;
      end
      ST_SRC_READ:  w_hold = data;
      ST_GPU_WRITE: if (w_next == ST_SRC_READ) w_index = r_index + 11'd1;
      ST_KICK:      w_poll = '0;
      ST_POST_POLL: begin
        if (w_next == ST_POST_POLL)        w_poll  = r_poll + 24'd1;
        else if (data[STAT_COPY_PENDING])  w_error = 1'b1;
      end
      default: ;
    endcase
    case (w_next)
      ST_PRE_POLL, ST_POST_POLL: begin
        w_read = 1'b1;
        w_addr = w_ctrl_addr;
      end
      ST_SRC_READ: begin
        w_read = 1'b1;
        w_addr = w_base + BUS_W'(w_index);
      end
      ST_GPU_WRITE: begin
        w_write = 1'b1;
        w_addr  = gpu_word_addr(GPUAddress, w_index + GPUCharactersAddressMin);
        w_wdata = w_hold;
      end
      ST_KICK: begin
        w_write = 1'b1;
        w_addr  = w_ctrl_addr;
        w_wdata = ctrl_kick_word(w_color, w_mode);
      end
      default: ;
    endcase
  end

  always_ff @(posedge procClock or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_mode  <= 1'b0;
      r_color <= '0;
      r_index <= '0;
      r_poll  <= '0;
      r_hold  <= '0;
      r_error <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_base  <= w_base;
      r_mode  <= w_mode;
      r_color <= w_color;
      r_index <= w_index;
      r_poll  <= w_poll;
      r_hold  <= w_hold;
      r_error <= w_error;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_read  <= w_read;
      r_write <= w_write;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
    end
  end

  assign data    = r_write ? r_wdata : {BUS_W{1'bz}};
  assign address = r_addr;
  assign read    = r_read;
  assign write   = r_write;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;

endmodule

// File: tb/tb_gpu_frame_uploader.sv
// Scoreboard bench for gpu_frame_uploader with a memory/GPU bus model.
module tb_gpu_frame_uploader;

  localparam int POLL  = 100;
  localparam int WORDS = 1200;
  localparam logic [63:0] CTRL_ADDR = 64'h0200_0000_0000_0000;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] dat;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] src_base;
  logic        disp_mode;
  logic [11:0] disp_color;
  logic        busy, done, error, rd, wr;
  logic [63:0] address;
  wire  [63:0] data;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   start_cyc, exp_done_rel, n_done, first_src_rel;
  logic exp_err;
  txn_t exp_q[$];

  logic [63:0] cur_base;
  logic [31:0] seed;
  int          cfg_pre, cfg_clear;
  logic [63:0] gpu_ctrl = 64'd0;
  int          pre_cnt  = 0;
  int          post_cnt = 0;
  logic [63:0] rd_data;

  gpu_frame_uploader #(.PollLimit(24'(POLL))) dut (
    .procClock   (clk),
    .reset       (rst),
    .start       (start),
    .srcBase     (src_base),
    .displayMode (disp_mode),
    .displayColor(disp_color),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .address     (address),
    .data        (data),
    .read        (rd),
    .write       (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: source word at offset i from the base is A000+i (+seed in the upper half)
  always_comb begin
    if (address[63:56] == 8'h02) rd_data = gpu_ctrl;
    else                         rd_data = 64'hA000 + (address - cur_base) + {seed, 32'h0};
  end
  assign data = wr ? {64{1'bz}} : rd_data;

  // GPU model: blank pending for cfg_pre cycles after start; copy bit clears cfg_clear cycles after kick
  always @(posedge clk) begin
    if (start && !busy && !rst) begin
      gpu_ctrl <= {62'd0, (cfg_pre > 0), 1'b0};
      pre_cnt  <= cfg_pre;
      post_cnt <= 0;
    end else begin
      if (pre_cnt > 0) begin
        pre_cnt <= pre_cnt - 1;
        if (pre_cnt == 1) gpu_ctrl[1] <= 1'b0;
      end
      if (wr && address == CTRL_ADDR && data[0]) begin
        gpu_ctrl <= data;
        post_cnt <= cfg_clear;
      end else if (post_cnt > 0) begin
        post_cnt <= post_cnt - 1;
        if (post_cnt == 1) gpu_ctrl[0] <= 1'b0;
      end
    end
  end

  function automatic void check(input string name, input logic ok,
                                input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every bus cycle and done pulse against the expectation queue
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      check("rd_wr_exclusive", !(rd && wr), {62'd0, rd, wr}, 64'd0);
      if (!rd && !wr) begin
        check("idle_address", address == 64'd0, address, 64'd0);
      end else if (wr) begin
        if (exp_q.size() == 0) check("unexpected_write", 1'b0, address, 64'd0);
        else begin
          t = exp_q.pop_front();
          check("write_addr", t.wr && address == t.addr, address, t.addr);
          check("write_data", data == t.dat, data, t.dat);
        end
      end else if (address[63:56] == 8'h02) begin
        check("poll_addr", address == CTRL_ADDR, address, CTRL_ADDR);
      end else begin
        if (first_src_rel < 0) first_src_rel = cyc - start_cyc + 1;
        if (exp_q.size() == 0) check("unexpected_read", 1'b0, address, 64'd0);
        else begin
          t = exp_q.pop_front();
          check("read_addr", !t.wr && address == t.addr, address, t.addr);
        end
      end
      if (done) begin
        n_done++;
        check("done_cycle", (cyc - start_cyc + 1) == exp_done_rel,
              64'(cyc - start_cyc + 1), 64'(exp_done_rel));
        check("done_error", error == exp_err, 64'(error), 64'(exp_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic load_expect(input logic [63:0] base, input logic m, input logic [11:0] c);
    txn_t t;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) begin
      t = '{1'b0, base + 64'(i), 64'd0};
      exp_q.push_back(t);
      t = '{1'b1, CTRL_ADDR | 64'(i + 4), 64'hA000 + 64'(i) + {seed, 32'h0}};
      exp_q.push_back(t);
    end
    t = '{1'b1, CTRL_ADDR, 64'h1 | (64'(c) << 3) | (64'(m) << 2)};
    exp_q.push_back(t);
  endtask

  task automatic pulse_start(input logic [63:0] base, input logic m, input logic [11:0] c);
    src_base   = base;
    disp_mode  = m;
    disp_color = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    start_cyc  = cyc;
    check("busy_on_accept", busy == 1'b1, 64'(busy), 64'd1);
    check("error_cleared_on_start", error == 1'b0, 64'(error), 64'd0);
  endtask

  task automatic run_xfer(input logic [63:0] base, input int pre, input int clr,
                          input logic err_exp, input int ign, input bit rand_seed);
    logic       m;
    logic [11:0] c;
    bit         seen;
    m         = 1'($urandom_range(0, 1));
    c         = 12'($urandom);
    cur_base  = base;
    seed      = rand_seed ? $urandom : 32'd0;
    cfg_pre   = pre;
    cfg_clear = clr;
    load_expect(base, m, c);
    exp_err      = err_exp;
    exp_done_rel = err_exp ? (2403 + POLL) : (2404 + pre + clr);
    n_done        = 0;
    first_src_rel = -1;
    pulse_start(base, m, c);
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (ign > 0 && wr && address != CTRL_ADDR && $urandom_range(0, 99) < 3) begin
          start = 1'b1;
          ign--;
        end
        tick();
        start = 1'b0;
      end
    end
    check("done_within_budget", seen, 64'(seen), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("busy_after_done", busy == 1'b0, 64'(busy), 64'd0);
    check("single_done", n_done == 1, 64'(n_done), 64'd1);
    check("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    check("error_sticky", error == err_exp, 64'(error), 64'(err_exp));
    check("first_src_read_cycle", first_src_rel == pre + 2, 64'(first_src_rel), 64'(pre + 2));
  endtask

  task automatic reset_mid();
    logic [11:0] c;
    bit          hit;
    c         = 12'($urandom);
    cur_base  = 64'h100;
    seed      = $urandom;
    cfg_pre   = 0;
    cfg_clear = 5;
    load_expect(64'h100, 1'b0, c);
    exp_err      = 1'b0;
    exp_done_rel = -1;
    first_src_rel = -1;
    pulse_start(64'h100, 1'b0, c);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (wr && address == (CTRL_ADDR | 64'd41)) hit = 1'b1;
      else tick();
    end
    check("reached_word_37", hit, 64'(hit), 64'd1);
    rst = 1'b1;
    #1;
    check("reset_read", rd == 1'b0, 64'(rd), 64'd0);
    check("reset_write", wr == 1'b0, 64'(wr), 64'd0);
    check("reset_address", address == 64'd0, address, 64'd0);
    check("reset_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("reset_data_released", data == rd_data, data, rd_data);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", busy == 1'b0 && done == 1'b0, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    src_base   = '0;
    disp_mode  = 1'b0;
    disp_color = '0;
    cur_base   = '0;
    seed       = '0;
    cfg_pre    = 0;
    cfg_clear  = 5;
    start_cyc  = 0;
    exp_done_rel  = -1;
    exp_err       = 1'b0;
    n_done        = 0;
    first_src_rel = -1;
    repeat (3) tick();
    check("rst_read", rd == 1'b0, 64'(rd), 64'd0);
    check("rst_write", wr == 1'b0, 64'(wr), 64'd0);
    check("rst_address", address == 64'd0, address, 64'd0);
    check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("rst_done", done == 1'b0, 64'(done), 64'd0);
    check("rst_error", error == 1'b0, 64'(error), 64'd0);
    rst = 1'b0;
    tick();

    run_xfer(64'h100, 0, 5, 1'b0, 0, 1'b0);
    run_xfer(64'h4000, 10, int'($urandom_range(1, 8)), 1'b0, 0, 1'b1);
    run_xfer(64'h2000, 0, -1, 1'b1, 0, 1'b1);
    run_xfer({8'h10, 24'($urandom), 32'($urandom)}, 0, int'($urandom_range(1, 8)), 1'b0, 0, 1'b1);
    reset_mid();
    run_xfer(64'h100, 0, 5, 1'b0, 0, 1'b1);
    run_xfer(64'hFFFF_FFFF_FFFF_FFF0, 0, int'($urandom_range(1, 8)), 1'b0, 0, 1'b1);
    run_xfer({8'h10, 24'($urandom), 32'($urandom)}, int'($urandom_range(0, 4)),
             int'($urandom_range(1, 8)), 1'b0, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
